// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qdec_pkg
// Purpose  : Shared types, constants and phase helpers for the quadrature
//            decoder (quad_decoder / qdec_sync_filter).
// Revision : 1.0 - initial release
// ============================================================================
package qdec_pkg;

  // Two-state control FSM, encoded as plain constants
  typedef logic [0:0] qdec_state_t;
  localparam qdec_state_t S_INIT  = 1'b0;
  localparam qdec_state_t S_TRACK = 1'b1;

  // Phase word is {a, b}; forward Gray order is 00 -> 01 -> 11 -> 10 -> 00
  typedef logic [1:0] phase_t;
  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  // Direction encoding shared with the up/down counter
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Flops in each phase synchroniser
  localparam int SYNC_STAGES = 2;

  // Phase that follows p when the encoder turns forward
  function automatic phase_t fwd_next(input phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

  // Phase that follows p when the encoder turns in reverse
  function automatic phase_t rev_next(input phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_10;
      PH_10:   n = PH_11;
      PH_11:   n = PH_01;
      default: n = PH_00;
    endcase
    return n;
  endfunction

endpackage : qdec_pkg
`default_nettype wire

// File: rtl/qdec_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : qdec_sync_filter
// Purpose  : Brings one asynchronous encoder phase into the clk domain through
//            a SYNC_STAGES-flop synchroniser. With QDEC_FILTER_EN defined, a
//            glitch filter follows: the output only moves after the
//            synchronised input has disagreed with it for FILT_LEN cycles.
// Macro    : QDEC_FILTER_EN (optional glitch filter)
// Revision : 1.0 - initial release
// ============================================================================
module qdec_sync_filter
  import qdec_pkg::*;
`ifdef QDEC_FILTER_EN
  #(parameter int FILT_LEN = 4)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  // Metastability chain: shift the raw pin through SYNC_STAGES flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
  localparam int                CNT_W    = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = filt_q;
`else
  assign sync_o = sync_s;
`endif

endmodule : qdec_sync_filter
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Purpose  : Quadrature decoder. Turns asynchronous A/B phases into a
//            one-cycle step pulse, a direction flag (1 = up) and a modular
//            WIDTH-bit position count, with a sticky illegal-transition flag.
// Macro    : QDEC_FILTER_EN (adds a FILT_LEN-cycle glitch filter per phase)
// Revision : 1.0 - initial release
// ============================================================================
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH    = 17,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             zero,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [WIDTH-1:0] pos
);

`ifdef QDEC_FILTER_EN
  localparam int FILT_CYCLES = FILT_LEN;
`else
  // Filter absent: it adds no cycles to start-up
  localparam int FILT_CYCLES = 0 * FILT_LEN;
`endif

  // Start-up waits until the synchroniser (and filter) hold post-reset pin
  // values, so stale reset contents can never be mistaken for a transition.
  localparam int               INIT_CYCLES = SYNC_STAGES + 1 + FILT_CYCLES;
  localparam int               CNT_W       = $clog2(INIT_CYCLES);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH-1:0] POS_ONE     = WIDTH'(1);

  logic        a_s, b_s;
  phase_t      phase;

  qdec_state_t      state_q,    state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  phase_t           prev_q,     prev_d;
  logic             step_q,     step_d;
  logic             dir_q,      dir_d;
  logic             err_q,      err_d;
  logic [WIDTH-1:0] pos_q,      pos_d;

`ifdef QDEC_FILTER_EN
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
    .clk(clk), .rst(rst), .raw_i(a), .sync_o(a_s)
  );
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
    .clk(clk), .rst(rst), .raw_i(b), .sync_o(b_s)
  );
`else
  qdec_sync_filter u_sync_a (
    .clk(clk), .rst(rst), .raw_i(a), .sync_o(a_s)
  );
  qdec_sync_filter u_sync_b (
    .clk(clk), .rst(rst), .raw_i(b), .sync_o(b_s)
  );
`endif

  assign phase = {a_s, b_s};

  // Decode: start-up capture of prev, then classify each phase change
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
    pos_d      = pos_q;

    if (state_q == S_INIT) begin
      if (init_cnt_q == INIT_LAST) begin
        prev_d  = phase;
        state_d = S_TRACK;
      end else begin
        init_cnt_d = init_cnt_q + CNT_ONE;
      end
    end else if (phase != prev_q) begin
      prev_d = phase;
      if (phase == fwd_next(prev_q)) begin
        step_d = 1'b1;
        dir_d  = DIR_UP;
        pos_d  = pos_q + POS_ONE;
      end else if (phase == rev_next(prev_q)) begin
        step_d = 1'b1;
        dir_d  = DIR_DOWN;
        pos_d  = pos_q - POS_ONE;
      end else begin
        // Both phases moved at once: position is unknowable, flag it
        err_d = 1'b1;
      end
    end

    // Clear overrides position and error only; step/dir/FSM carry on
    if (zero) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      prev_q     <= PH_00;
      step_q     <= 1'b0;
      dir_q      <= DIR_DOWN;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;
  assign pos  = pos_q;

endmodule : quad_decoder
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Purpose  : Self-checking bench for quad_decoder. Stimulus pushes expected
//            {dir,pos} for every legal edge; a negedge monitor pops and
//            compares whenever step is high.
// Macro    : QDEC_FILTER_EN (selects filtered latency and glitch test)
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;
  import qdec_pkg::*;

  localparam int WIDTH    = 17;
  localparam int FILT_LEN = 4;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 4;

  typedef struct packed {
    logic             dir;
    logic [WIDTH-1:0] pos;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             a, b, zero;
  logic             step, dir, err;
  logic [WIDTH-1:0] pos;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               total = 0;
  int               bad   = 0;

  // Reference model state
  phase_t           m_prev;
  logic [WIDTH-1:0] m_pos;

  quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .zero(zero),
    .step(step), .dir(dir), .err(err), .pos(pos)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every step pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && step) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_step: got dir=%0d pos=%0d, none expected", dir, pos);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dir, pos} !== mon_e) begin
          bad++;
          $display("FAIL step_value: got dir=%0d pos=%0d, want dir=%0d pos=%0d",
                   dir, pos, mon_e.dir, mon_e.pos);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Apply a new phase, predict the result, then hold it
  task automatic drive_phase(input phase_t ph, input int hold);
    if (ph != m_prev) begin
      if (ph == fwd_next(m_prev)) begin
        m_pos = m_pos + 1'b1;
        exp_q.push_back('{dir: 1'b1, pos: m_pos});
      end else if (ph == rev_next(m_prev)) begin
        m_pos = m_pos - 1'b1;
        exp_q.push_back('{dir: 1'b0, pos: m_pos});
      end
      m_prev = ph;
    end
    a = ph[1];
    b = ph[0];
    tick(hold);
  endtask

  initial begin
    int first;
    phase_t ph;

    rst = 1'b0; a = 1'b0; b = 1'b0; zero = 1'b0;
    m_prev = PH_00; m_pos = '0;
    tick(4);
    check("reset_step", 32'(step), 32'd0);
    check("reset_dir",  32'(dir),  32'd0);
    check("reset_err",  32'(err),  32'd0);
    check("reset_pos",  32'(pos),  32'd0);
    rst = 1'b1;
    tick(12);

    // 1: 32 forward edges
    ph = PH_00;
    for (int i = 0; i < 32; i++) begin
      ph = fwd_next(ph);
      drive_phase(ph, HOLD);
    end
    tick(LAT + 2);
    check("fwd_pos", 32'(pos), 32'd32);
    check("fwd_dir", 32'(dir), 32'd1);
    check("fwd_err", 32'(err), 32'd0);

    // 2: 40 reverse edges, wrapping through zero
    for (int i = 0; i < 40; i++) begin
      ph = rev_next(ph);
      drive_phase(ph, HOLD);
    end
    tick(LAT + 2);
    check("rev_pos", 32'(pos), 32'd131064);
    check("rev_dir", 32'(dir), 32'd0);
    check("rev_err", 32'(err), 32'd0);

    // 3: illegal 00 -> 11, then clear
    drive_phase(PH_11, LAT + 2);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_pos", 32'(pos), 32'd131064);
    tick(5);
    check("err_sticky", 32'(err), 32'd1);
    zero = 1'b1;
    tick(1);
    zero = 1'b0;
    m_pos = '0;
    check("zero_err", 32'(err), 32'd0);
    check("zero_pos", 32'(pos), 32'd0);

    // 4: zero coincident with a forward step (11 -> 10)
    exp_q.push_back('{dir: 1'b1, pos: '0});
    m_prev = PH_10;
    a = 1'b1; b = 1'b0;
    tick(LAT - 1);
    zero = 1'b1;
    tick(1);
    zero = 1'b0;
    tick(HOLD);
    check("zero_step_pos", 32'(pos), 32'd0);
    check("zero_step_dir", 32'(dir), 32'd1);

    // 5: reset mid-operation with a toggling, release at phase 01
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = ~a;
      tick(1);
    end
    check("rst2_dir", 32'(dir), 32'd0);
    check("rst2_pos", 32'(pos), 32'd0);
    a = 1'b0; b = 1'b1;
    rst = 1'b1;
    m_prev = PH_01; m_pos = '0;
    tick(LAT + 8);
    check("init_pos", 32'(pos), 32'd0);
    drive_phase(PH_11, LAT + 2);
    check("first_edge_pos", 32'(pos), 32'd1);

`ifdef QDEC_FILTER_EN
    // 6a: 3-cycle glitch on a must be invisible
    a = 1'b0;
    tick(FILT_LEN - 1);
    a = 1'b1;
    tick(LAT + 4);
    check("glitch_pos", 32'(pos), 32'd1);
`endif

    // Pin-to-step latency on a legal edge 11 -> 10
    m_pos = m_pos + 1'b1;
    exp_q.push_back('{dir: 1'b1, pos: m_pos});
    m_prev = PH_10;
    a = 1'b1; b = 1'b0;
    first = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(1);
      if (step && first == 0) first = k;
    end
    check("latency", 32'(first), 32'(LAT));

`ifndef QDEC_FILTER_EN
    // Back-to-back edges on consecutive cycles give consecutive steps
    for (int i = 0; i < 4; i++) begin
      ph = fwd_next(m_prev);
      drive_phase(ph, 1);
    end
    tick(LAT + 3);
    check("b2b_pos", 32'(pos), 32'd6);
`else
    tick(2);
    check("final_pos", 32'(pos), 32'd2);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_quad_decoder
`default_nettype wire
